// File: rtl/baud_pkg.sv
// Shared types and divisor math for the baud/oversample timebase.
package baud_pkg;

    localparam int unsigned OS_DEFAULT      = 16;
    localparam int unsigned PHASE_W_DEFAULT = $clog2(OS_DEFAULT);
    localparam int unsigned DIV_W_DEFAULT   = 16;
    localparam int unsigned FRAC_W_DEFAULT  = 8;

    typedef struct packed {
        logic [DIV_W_DEFAULT-1:0]  i;
        logic [FRAC_W_DEFAULT-1:0] f;
    } div_t;

    // Returns {int[31:0], frac[31:0]}; frac is rounded to nearest 2^-frac_w.
    function automatic logic [63:0] calc_div(input longint clk_hz, input longint baud,
                                             input longint os, input int frac_w);
        longint rate;
        longint ip;
        longint rem;
        longint fp;
        rate = baud * os;
        ip   = clk_hz / rate;
        rem  = clk_hz - (ip * rate);
        fp   = ((rem << frac_w) + (rate / 64'sd2)) / rate;
        if (fp >= (64'sd1 << frac_w)) begin
            ip = ip + 64'sd1;
            fp = 64'sd0;
        end
        return {ip[31:0], fp[31:0]};
    endfunction

endpackage

// File: rtl/baud_tick_gen_frac_period_ctr.sv
// Fractional interval counter: cnt/acc/carry state, os_tick and clk_os generation.
module frac_period_ctr #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic              clear_i,
    input  logic              pend_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    output logic              tick_due_o,
    output logic              os_tick_o,
    output logic              clk_os_o
);

    localparam int unsigned CW = DIV_W + 1;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic              os_tick_q, os_tick_d;
    logic              clk_os_q, clk_os_d;
    logic [DIV_W-1:0]  int_clamped_s;
    logic [CW-1:0]     period_s;
    logic [CW-1:0]     half_s;
    logic              tick_due_s;

    // Intervals shorter than two cycles cannot carry a low and a high clk_os phase.
    always_comb begin
        if (div_int_i < DIV_W'(2'd2)) begin
            int_clamped_s = DIV_W'(2'd2);
        end else begin
            int_clamped_s = div_int_i;
        end
    end

    assign period_s   = {1'b0, int_clamped_s} + CW'(carry_q);
    assign half_s     = period_s >> 1;
    assign tick_due_s = run_i && !clear_i && (cnt_q >= (period_s - CW'(1'b1)));

    // Next-state for the interval counter and fractional accumulator.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        carry_d   = carry_q;
        os_tick_d = 1'b0;
        clk_os_d  = 1'b0;
        if (!run_i || clear_i) begin
            cnt_d   = '0;
            acc_d   = '0;
            carry_d = 1'b0;
        end else if (tick_due_s) begin
            cnt_d     = '0;
            os_tick_d = 1'b1;
            if (pend_i) begin
                acc_d   = '0;
                carry_d = 1'b0;
            end else begin
                {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, div_frac_i};
            end
        end else begin
            cnt_d    = cnt_q + CW'(1'b1);
            clk_os_d = (cnt_d >= half_s);
        end
    end

    // Counter state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            os_tick_q <= 1'b0;
            clk_os_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            carry_q   <= carry_d;
            os_tick_q <= os_tick_d;
            clk_os_q  <= clk_os_d;
        end
    end

    assign tick_due_o = tick_due_s;
    assign os_tick_o  = os_tick_q;
    assign clk_os_o   = clk_os_q;

endmodule

// File: rtl/baud_tick_gen.sv
// Baud/oversample timebase: shadowed run-time divisor, phase counter, bit/mid ticks, resync.
module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          div_load,
    input  logic                          resync,
    output logic                          os_tick,
    output logic                          bit_tick,
    output logic                          mid_tick,
    output logic                          clk_os,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic                          div_pending
);

    localparam int unsigned       PH_W     = $clog2(OVERSAMPLE);
    localparam logic [63:0]       DEF_DIV  = calc_div(longint'(CLK_HZ), longint'(BAUD),
                                                      longint'(OVERSAMPLE), int'(FRAC_W));
    localparam logic [DIV_W-1:0]  DEF_INT  = DEF_DIV[32 +: DIV_W];
    localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_DIV[0 +: FRAC_W];
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0]   PH_MID   = PH_W'((OVERSAMPLE / 2) - 1);

    logic [DIV_W-1:0]  act_int_q, act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  shd_int_q, shd_int_d;
    logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
    logic              pend_q, pend_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              bit_q, bit_d;
    logic              mid_q, mid_d;
    logic              tick_due_s;

    frac_period_ctr #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_ctr (
        .clk_i      (CLOCK_50),
        .rst_ni     (reset_n),
        .run_i      (enable),
        .clear_i    (resync),
        .pend_i     (pend_q),
        .div_int_i  (act_int_q),
        .div_frac_i (act_frac_q),
        .tick_due_o (tick_due_s),
        .os_tick_o  (os_tick),
        .clk_os_o   (clk_os)
    );

    // Divisor shadow/apply, phase tracking and derived tick decode.
    always_comb begin
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        shd_int_d  = shd_int_q;
        shd_frac_d = shd_frac_q;
        pend_d     = pend_q;
        phase_d    = phase_q;
        bit_d      = 1'b0;
        mid_d      = 1'b0;
        if (!enable) begin
            phase_d = '0;
            pend_d  = 1'b0;
            if (div_load) begin
                act_int_d  = div_int;
                act_frac_d = div_frac;
            end else if (pend_q) begin
                act_int_d  = shd_int_q;
                act_frac_d = shd_frac_q;
            end else begin
                act_int_d  = act_int_q;
            end
        end else if (resync) begin
            phase_d = '0;
            if (pend_q) begin
                act_int_d  = shd_int_q;
                act_frac_d = shd_frac_q;
            end else begin
                act_int_d  = act_int_q;
            end
            // A load coinciding with resync waits for the next tick boundary.
            if (div_load) begin
                shd_int_d  = div_int;
                shd_frac_d = div_frac;
                pend_d     = 1'b1;
            end else begin
                pend_d     = 1'b0;
            end
        end else begin
            if (tick_due_s) begin
                bit_d = (phase_q == PH_LAST);
                mid_d = (phase_q == PH_MID);
                phase_d = (phase_q == PH_LAST) ? '0 : (phase_q + PH_W'(1'b1));
                if (pend_q) begin
                    act_int_d  = shd_int_q;
                    act_frac_d = shd_frac_q;
                    pend_d     = 1'b0;
                end else begin
                    pend_d     = pend_q;
                end
            end else begin
                phase_d = phase_q;
            end
            if (div_load) begin
                shd_int_d  = div_int;
                shd_frac_d = div_frac;
                pend_d     = 1'b1;
            end else begin
                shd_int_d  = shd_int_q;
            end
        end
    end

    // Control state and registered tick outputs.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            act_int_q  <= DEF_INT;
            act_frac_q <= DEF_FRAC;
            shd_int_q  <= DEF_INT;
            shd_frac_q <= DEF_FRAC;
            pend_q     <= 1'b0;
            phase_q    <= '0;
            bit_q      <= 1'b0;
            mid_q      <= 1'b0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
            pend_q     <= pend_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            mid_q      <= mid_d;
        end
    end

    assign bit_tick    = bit_q;
    assign mid_tick    = mid_q;
    assign os_phase    = phase_q;
    assign div_pending = pend_q;

endmodule
